mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the team's shared 4:1, N-bit mux datapath.
- Four requesters each present an N-bit word plus a request. The block picks one fairly and drives the mux select `s`.
- It registers the selected word into a single-entry output stage with a valid/ready handshake.
- It returns a one-cycle grant pulse to the requester whose word was consumed.

---
 rtl/mux_arb_pkg.sv | 23 ++
 rtl/mux4.sv | 27 ++
 rtl/rr_pick4.sv | 31 +++
 rtl/mux4_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin arbiter in front of the 4:1 mux.
//   NREQ   : number of requesters (4)
//   SEL_W  : width of the mux select / requester index (2)
//   state_t: sequencer state (IDLE = no beat held, BUSY = beat held)
//   onehot : index -> one-hot request/grant vector
package mux_arb_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4.sv
// Shared 4:1 N-bit datapath mux.
//   sel    : select
//   i0..i3 : data inputs
//   y      : selected word
module mux4 #(
  parameter int unsigned N = 8
) (
  input  logic [1:0]   sel,
  input  logic [N-1:0] i0,
  input  logic [N-1:0] i1,
  input  logic [N-1:0] i2,
  input  logic [N-1:0] i3,
  output logic [N-1:0] y
);

  always_comb begin
    y = '0;
    unique case (sel)
      2'd0: y = i0;
      2'd1: y = i1;
      2'd2: y = i2;
      2'd3: y = i3;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker.
//   mask  : candidate requests
//   ptr   : highest-priority index; scan order is ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   win   : first set bit in scan order (0 when nothing is set)
//   found : high when mask has any bit set
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             found
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // 2-bit add wraps naturally, giving the mod-4 scan.
      idx = ptr + SEL_W'(k);
      if (!found && mask[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4:1 N-bit mux.
// Picks one of four requesters fairly, registers its word into a
// single-entry valid/ready output stage, and pulses gnt to the requester
// whose beat is consumed.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : request per requester (req[k] <-> ik)
//   i0..i3    : requester words
//   s         : registered select of current/last winner
//   out_data  : registered winner word
//   out_valid : out_data holds an unconsumed beat
//   out_ready : downstream accept
//   gnt       : one-hot pulse in the acceptance cycle
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [N-1:0]     i0,
  input  logic [N-1:0]     i1,
  input  logic [N-1:0]     i2,
  input  logic [N-1:0]     i3,
  output logic [SEL_W-1:0] s,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NREQ-1:0]  gnt
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] s_nxt;
  logic [N-1:0]     data_nxt;

  logic [NREQ-1:0]  pick_mask;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] win;
  logic             found;
  logic [N-1:0]     mux_y;
  logic             accept;

  assign accept    = (state == BUSY) && out_ready;
  assign out_valid = (state == BUSY);
  assign gnt       = accept ? onehot(s) : '0;

  // One picker serves both the idle arbitration and the back-to-back
  // re-arbitration: in BUSY it sees the requests minus the current winner
  // and starts scanning from the pointer value being written this cycle.
  always_comb begin
    pick_mask = req;
    pick_ptr  = ptr;
    if (state == BUSY) begin
      pick_mask = req & ~onehot(s);
      pick_ptr  = s + SEL_W'(1);
    end
  end

  rr_pick4 u_pick (
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .win   (win),
    .found (found)
  );

  mux4 #(.N(N)) u_mux (
    .sel (win),
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .i3  (i3),
    .y   (mux_y)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    s_nxt     = s;
    data_nxt  = out_data;
    unique case (state)
      IDLE: begin
        if (found) begin
          s_nxt     = win;
          data_nxt  = mux_y;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (out_ready) begin
          ptr_nxt = s + SEL_W'(1);
          if (found) begin
            s_nxt    = win;
            data_nxt = mux_y;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      s        <= '0;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      s        <= s_nxt;
      out_data <= data_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] i0, i1, i2, i3;
  logic [1:0] s;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] gnt;

  int unsigned errors;
  int unsigned checks;
  beat_t       exp_q[$];

  beat_t       mon_e;
  logic [3:0]  mon_gnt;
  logic        prev_valid;
  logic        prev_acc;

  mux4_rr_arbiter #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .i0        (i0),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .s         (s),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gnt       (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every accepted beat must match the next expected
  // beat, and gnt must be zero whenever no beat is accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: s=%0d data=%h gnt=%b, none expected", s, out_data, gnt);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_gnt = 4'b0001 << mon_e.idx;
          if (s !== mon_e.idx || out_data !== mon_e.data || gnt !== mon_gnt) begin
            errors++;
            $display("FAIL beat: got s=%0d data=%h gnt=%b, want s=%0d data=%h gnt=%b",
                     s, out_data, gnt, mon_e.idx, mon_e.data, mon_gnt);
          end
        end
      end else begin
        checks++;
        if (gnt !== 4'b0000) begin
          errors++;
          $display("FAIL gnt_without_accept: gnt=%b valid=%b ready=%b, want gnt=0000", gnt, out_valid, out_ready);
        end
      end
      checks++;
      if (prev_valid && !prev_acc && !out_valid) begin
        errors++;
        $display("FAIL valid_dropped: out_valid=0 without acceptance, want 1");
      end
      prev_valid = out_valid;
      prev_acc   = out_valid && out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] data);
    beat_t b;
    b.idx  = idx;
    b.data = data;
    exp_q.push_back(b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0; i0 = '0; i1 = '0; i2 = '0; i3 = '0; out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({s, out_data, out_valid, gnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: s=%0d data=%h valid=%b gnt=%b, want all 0", s, out_data, out_valid, gnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0010; i1 = 8'h01; out_ready = 1'b0;
    push(2'd1, 8'h01);
    tick();
    checks++;
    if ({out_valid, s, out_data} !== {1'b1, 2'd1, 8'h01}) begin
      errors++;
      $display("FAIL single_capture: valid=%b s=%0d data=%h, want 1/1/01", out_valid, s, out_data);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({out_valid, s, out_data} !== {1'b1, 2'd1, 8'h01}) begin
        errors++;
        $display("FAIL single_hold: valid=%b s=%0d data=%h, want 1/1/01", out_valid, s, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    req = 4'b0000;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: valid=%b, want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_rotation();
    logic [1:0] want;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    i0 = 8'h00; i1 = 8'h01; i2 = 8'h02; i3 = 8'h03;
    out_ready = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      want = 2'(k % 4);
      push(want, 8'(k % 4));
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      want = 2'(k % 4);
      checks++;
      if (out_valid !== 1'b1 || s !== want) begin
        errors++;
        $display("FAIL rotation[%0d]: valid=%b s=%0d, want 1/%0d", k, out_valid, s, want);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rotation_end: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_wrap_skip();
    out_ready = 1'b1;
    req = 4'b1000; i3 = 8'h33;
    push(2'd3, 8'h33);
    tick();
    req = 4'b0000;
    checks++;
    if (s !== 2'd3) begin
      errors++;
      $display("FAIL wrap_grant3: s=%0d, want 3", s);
    end
    tick();
    req = 4'b0100; i2 = 8'h22;
    push(2'd2, 8'h22);
    tick();
    req = 4'b0000;
    checks++;
    if (s !== 2'd2 || out_data !== 8'h22) begin
      errors++;
      $display("FAIL skip_to2: s=%0d data=%h, want 2/22", s, out_data);
    end
    tick();
    req = 4'b1001; i0 = 8'hA0; i3 = 8'hA3;
    push(2'd3, 8'hA3);
    push(2'd0, 8'hA0);
    tick();
    checks++;
    if (s !== 2'd3 || out_data !== 8'hA3) begin
      errors++;
      $display("FAIL ptr3_first: s=%0d data=%h, want 3/a3", s, out_data);
    end
    req = 4'b0001;
    tick();
    checks++;
    if (s !== 2'd0 || out_data !== 8'hA0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ptr3_then0: s=%0d data=%h valid=%b, want 0/a0/1", s, out_data, out_valid);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_drop();
    out_ready = 1'b0;
    req = 4'b0100; i2 = 8'h5A;
    push(2'd2, 8'h5A);
    tick();
    req = 4'b0000; i2 = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({out_valid, s, out_data} !== {1'b1, 2'd2, 8'h5A}) begin
        errors++;
        $display("FAIL drop_hold: valid=%b s=%0d data=%h, want 1/2/5a", out_valid, s, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    req = 4'b1000; i3 = 8'hC3;
    tick();
    req = 4'b0000;
    checks++;
    if (s !== 2'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: s=%0d valid=%b, want 3/1", s, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    out_ready = 1'b1;
    #0;
    checks++;
    if ({s, out_data, out_valid, gnt} !== 15'd0) begin
      errors++;
      $display("FAIL areset_clear: s=%0d data=%h valid=%b gnt=%b, want all 0", s, out_data, out_valid, gnt);
    end
    tick();
    rst_n = 1'b1;
    i0 = 8'hB0; i3 = 8'hD3;
    req = 4'b1001;
    push(2'd0, 8'hB0);
    push(2'd3, 8'hD3);
    tick();
    checks++;
    if (s !== 2'd0 || out_data !== 8'hB0) begin
      errors++;
      $display("FAIL areset_ptr0: s=%0d data=%h, want 0/b0", s, out_data);
    end
    req = 4'b1000;
    tick();
    checks++;
    if (s !== 2'd3 || out_data !== 8'hD3) begin
      errors++;
      $display("FAIL areset_next3: s=%0d data=%h, want 3/d3", s, out_data);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_end: valid=%b, want 0", out_valid);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    prev_valid = 1'b0;
    prev_acc   = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap_skip();
    test_drop();
    test_async_reset();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats: %0d expected beats never accepted, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
